// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1101 sequence detector and its match monitor.
package seq_det_pkg;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_POS_W = 16;

   localparam logic [3:0] MATCH_PATTERN = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ALERT = 2'd2
   } mon_state_e;

endpackage

// File: rtl/seq_match_monitor_if.sv
// Control, match-pulse and snapshot-readout signals of the match monitor.
interface seq_match_monitor_if
   import seq_det_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int POS_W = DEF_POS_W
);

   logic             enable;
   logic             detect;
   logic [CNT_W-1:0] thresh;
   logic             rd_req;
   logic             rd_ack;
   logic [CNT_W-1:0] rd_count;
   logic [POS_W-1:0] rd_last_pos;
   logic             rd_overflow;
   logic             irq;

   modport master (
      output enable, detect, thresh, rd_req,
      input  rd_ack, rd_count, rd_last_pos, rd_overflow, irq
   );

   modport slave (
      input  enable, detect, thresh, rd_req,
      output rd_ack, rd_count, rd_last_pos, rd_overflow, irq
   );

endinterface

// File: rtl/seq_match_monitor_sat_counter.sv
// Saturating up-counter with clear; clear wins but still honours a same-cycle increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o,
   output logic [W-1:0] count_nxt_o,
   output logic         ovf_o
);

   logic [W-1:0] count_q, count_d;
   logic         ovf_q, ovf_d;

   always_comb begin
      // NOTE: defaults first so every path assigns; a missed branch would infer a latch.
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clr_i) begin
         count_d = inc_i ? W'(1) : '0;
         ovf_d   = 1'b0;
      end else if (inc_i) begin
         if (&count_q) ovf_d   = 1'b1;
         else          count_d = count_q + W'(1);
      end
   end

   // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o     = count_q;
   assign count_nxt_o = count_d;
   assign ovf_o       = ovf_q;

endmodule

// File: rtl/seq_match_monitor.sv
// Match monitor: counts detector pulses, tracks last match position, threshold irq, clear-on-read snapshot.
module seq_match_monitor
   import seq_det_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int POS_W = DEF_POS_W
) (
   input  logic                clk,
   input  logic                reset_n,
   seq_match_monitor_if.slave  bus
);

   mon_state_e       state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] last_pos_q, last_pos_d;
   logic [CNT_W-1:0] match_cnt, match_cnt_nxt;
   logic             ovf;

   logic             rd_ack_q;
   logic [CNT_W-1:0] rd_count_q;
   logic [POS_W-1:0] rd_last_pos_q;
   logic             rd_ovf_q;

   logic snap, start, running;

   // A snapshot fires only on the rising phase of the handshake.
   assign snap    = bus.rd_req & ~rd_ack_q;
   assign start   = (state_q == ST_IDLE) & bus.enable;
   assign running = (state_q != ST_IDLE) & bus.enable;

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk         (clk),
      .rst_n       (reset_n),
      .inc_i       (running & bus.detect),
      .clr_i       (start | snap),
      .count_o     (match_cnt),
      .count_nxt_o (match_cnt_nxt),
      .ovf_o       (ovf)
   );

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      last_pos_d = last_pos_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable) begin
               state_d    = ST_RUN;
               pos_d      = '0;
               last_pos_d = '0;
            end
         end
         ST_RUN, ST_ALERT: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
            end else begin
               pos_d = pos_q + POS_W'(1);
               if (bus.detect) last_pos_d = pos_q;
               if (state_q == ST_ALERT) begin
                  if (snap) state_d = ST_RUN;
               end else if ((bus.thresh != '0) && (match_cnt_nxt == bus.thresh)) begin
                  state_d = ST_ALERT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pos_q      <= '0;
         last_pos_q <= '0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         last_pos_q <= last_pos_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ack_q      <= 1'b0;
         rd_count_q    <= '0;
         rd_last_pos_q <= '0;
         rd_ovf_q      <= 1'b0;
      end else begin
         rd_ack_q <= bus.rd_req;
         if (snap) begin
            rd_count_q    <= match_cnt;
            rd_last_pos_q <= last_pos_q;
            rd_ovf_q      <= ovf;
         end
      end
   end

   assign bus.rd_ack      = rd_ack_q;
   assign bus.rd_count    = rd_count_q;
   assign bus.rd_last_pos = rd_last_pos_q;
   assign bus.rd_overflow = rd_ovf_q;
   assign bus.irq         = (state_q == ST_ALERT);

endmodule
